dct2_sequencer: RTL and testbench

DCT2_SEQUENCER -- requirements
Module: dct2_sequencer

---
 rtl/dct2_sequencer.sv | 129 ++++++++++++
 tb/tb_dct2_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dct2_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dct2_sequencer                                             |
// | Description : Transpose buffer between the two passes of an 8x8 2-D DCT. |
// |               Collects eight first-pass rows, then presents the block    |
// |               column by column to the second-pass datapath and registers |
// |               each result under a valid/ready handshake.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dct2_sequencer #(
  parameter int IN_W  = 72,
  parameter int OUT_W = 80
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic [IN_W-1:0]  dct_in,
  output logic [2:0]       dct_sel,
  input  logic [OUT_W-1:0] dct_out,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);

  localparam int EL_W = IN_W / 8;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [2:0]      r;
  logic [2:0]      c;
  logic            row_wr;
  logic            load;
  logic [EL_W-1:0] row_buf [8][8];
  logic [IN_W-1:0] col_data;
  logic [IN_W-1:0] hold_col;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_next;
  end

  // Next-state decode plus row-write / result-load strobes
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    row_wr     = 1'b0;
    load       = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        row_wr   = in_valid;
        if (in_valid && (r == 3'd7)) state_next = DRAIN;
      end
      DRAIN: begin
        load = !out_valid || out_ready;
        if (load && (c == 3'd7)) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  // Row counter advances per accepted row, column counter per loaded result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= 3'd0;
      c <= 3'd0;
    end else begin
      if (row_wr) r <= r + 3'd1;
      if (row_wr && (r == 3'd7)) c <= 3'd0;
      else if (load)             c <= c + 3'd1;
    end
  end

  // Transpose storage; contents are don't-care after reset so no reset here
  always_ff @(posedge clk) begin
    if (row_wr) begin
      for (int j = 0; j < 8; j++) begin
        row_buf[r][j] <= in_data[IN_W-1-EL_W*j -: EL_W];
      end
    end
  end

  // Gather column c, row 0 in the most significant element slot
  always_comb begin
    col_data = '0;
    for (int i = 0; i < 8; i++) begin
      col_data[IN_W-1-EL_W*i -: EL_W] = row_buf[i][c];
    end
  end

  // Remember the last driven column so dct_in stays quiet while refilling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              hold_col <= '0;
    else if (state == DRAIN) hold_col <= col_data;
  end

  assign dct_in  = (state == DRAIN) ? col_data : hold_col;
  assign dct_sel = (state == DRAIN) ? c : 3'd7;

  // Output register: load a new column or retire the accepted one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_last  <= (c == 3'd7);
      out_data  <= dct_out;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  assign busy = (state == DRAIN) || (r != 3'd0) || out_valid;

endmodule
`default_nettype wire

// File: tb/tb_dct2_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dct2_sequencer                                          |
// | Description : Directed, table-driven bench for dct2_sequencer with an    |
// |               identity second-pass stub (dct_out = {dct_in, 8'h00}).     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dct2_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [71:0] in_data;
  logic        in_ready;
  logic [71:0] dct_in;
  logic [2:0]  dct_sel;
  logic [79:0] dct_out;
  logic        out_valid;
  logic [79:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0][71:0] rows;
    logic [7:0][79:0] exp;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  assign dct_out = {dct_in, 8'h00};

  dct2_sequencer #(.IN_W(72), .OUT_W(80)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dct_in(dct_in), .dct_sel(dct_sel), .dct_out(dct_out),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] row_of(input int b, input int i);
    return vecs[b].rows[i];
  endfunction

  task automatic feed_rows(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = row_of(b, i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Continuous stream: rows every cycle, junk offered during drain, out_ready=1.
  task automatic run_stream(input int first, input int count);
    for (int b = first; b < first + count; b++) begin
      for (int t = 0; t < 16; t++) begin
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = (t < 8) ? row_of(b, t) : (72'hA5_A5A5_A5A5_A5A5_A5A5 ^ 72'(t));
        @(negedge clk);
        check("in_ready", in_ready, (t < 8) ? 80'd1 : 80'd0);
        check("busy", busy, (t == 0 && b == first) ? 80'd0 : 80'd1);
        if (t < 8) begin
          check("dct_sel_fill", dct_sel, 80'd7);
        end else begin
          check("dct_sel_drain", dct_sel, 80'(t - 8));
          check("dct_in_col", dct_in, vecs[b].exp[t-8][79:8]);
        end
        if (t == 3 && b > first)
          check("dct_in_hold", dct_in, vecs[b-1].exp[7][79:8]);
        if (t >= 9) begin
          check("out_valid", out_valid, 80'd1);
          check("out_data", out_data, vecs[b].exp[t-9]);
          check("out_last", out_last, 80'd0);
        end else if (t == 0 && b > first) begin
          check("out_valid_c7", out_valid, 80'd1);
          check("out_data_c7", out_data, vecs[b-1].exp[7]);
          check("out_last_c7", out_last, 80'd1);
        end else begin
          check("out_idle", out_valid, 80'd0);
        end
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", out_valid, 80'd1);
    check("flush_data", out_data, vecs[first+count-1].exp[7]);
    check("flush_last", out_last, 80'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("flush_idle_valid", out_valid, 80'd0);
    check("flush_idle_busy", busy, 80'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int beat;
    int stall;
    int cyc;
    logic [8:0] el;

    // Vector table
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        vecs[0].rows[i][71-9*j -: 9] = 9'(i);
        vecs[1].rows[i][71-9*j -: 9] = 9'(8*i + j);
        vecs[2].rows[i][71-9*j -: 9] = 9'h1FF - 9'(8*i + j);
        vecs[3].rows[i][71-9*j -: 9] = 9'($urandom_range(0, 511));
      end
    end
    for (int k = 0; k < 8; k++) begin
      vecs[0].exp[k] = {9'd0, 9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6, 9'd7, 8'h00};
      vecs[1].exp[k] = '0;
      vecs[2].exp[k] = '0;
      vecs[3].exp[k] = '0;
      for (int i = 0; i < 8; i++) begin
        vecs[1].exp[k][79-9*i -: 9] = 9'(8*i + k);
        vecs[2].exp[k][79-9*i -: 9] = 9'h1FF - 9'(8*i + k);
        el = vecs[3].rows[i][71-9*k -: 9];
        vecs[3].exp[k][79-9*i -: 9] = el;
      end
    end

    // Reset values
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 80'd0);
    check("rst_out_last", out_last, 80'd0);
    check("rst_out_data", out_data, 80'd0);
    check("rst_dct_sel", dct_sel, 80'd7);
    check("rst_busy", busy, 80'd0);
    check("rst_in_ready", in_ready, 80'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back table blocks
    run_stream(0, 4);

    // Backpressure: stall 5 cycles while column 3 is presented
    out_ready = 1'b1;
    feed_rows(1, 8);
    beat = 0; stall = 0; cyc = 0;
    while (beat < 8 && cyc < 40) begin
      @(negedge clk);
      if (out_valid) begin
        if (beat == 3 && stall < 5) begin
          out_ready = 1'b0;
          check("stall_data", out_data, vecs[1].exp[3]);
          check("stall_sel", dct_sel, 80'd4);
          stall++;
        end else begin
          out_ready = 1'b1;
          check("bp_data", out_data, vecs[1].exp[beat]);
          check("bp_last", out_last, (beat == 7) ? 80'd1 : 80'd0);
          beat++;
        end
      end else begin
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("bp_beats", 80'(beat), 80'd8);
    check("bp_stalls", 80'(stall), 80'd5);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset after six rows, then a clean block
    feed_rows(3, 6);
    #2 rst_n = 1'b0;
    #1;
    check("rstf_busy", busy, 80'd0);
    check("rstf_valid", out_valid, 80'd0);
    check("rstf_sel", dct_sel, 80'd7);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_stream(2, 1);

    // Reset mid-drain with a result pending, then a clean block
    out_ready = 1'b0;
    feed_rows(0, 8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_valid", out_valid, 80'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstd_valid", out_valid, 80'd0);
    check("rstd_busy", busy, 80'd0);
    check("rstd_data", out_data, 80'd0);
    check("rstd_last", out_last, 80'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_stream(3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
